// File: rtl/pe_pkg.sv
// pe_pkg
//   Shared constants and types for the processing-element MAC controller.
//   DATA_W : signed weight/ifmap width
//   ADDR_W : scratchpad address width (64 entries)
//   PSUM_W : signed partial-sum / accumulator width
//   PSUM_MAX / PSUM_MIN : saturation limits for the default PSUM_W
//   state_t : controller FSM states
package pe_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int PSUM_W = 20;

  localparam logic [PSUM_W-1:0] PSUM_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] PSUM_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/pe_mac_unit.sv
// pe_mac_unit
//   Two-stage signed multiply-accumulate datapath. The product of w*x is
//   registered on the edge where mul_en is high; the registered product is
//   sign-extended and added into the accumulator on the following edge.
//   Build option: define PE_PSUM_SAT_EN to saturate every accumulate to the
//   signed PSUM_W range; otherwise the accumulator wraps. Loads are never
//   saturated. Timing is the same in both builds.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : zero the accumulator and flush the product pipeline
//   load       : acc <= load_data (takes priority over accumulate)
//   load_data  : value loaded into the accumulator
//   mul_en     : capture w*x into the product register this edge
//   w, x       : signed multiplier operands
//   acc        : accumulator value
module pe_mac_unit #(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int PSUM_W = pe_pkg::PSUM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [PSUM_W-1:0]        load_data,
  input  logic                     mul_en,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] x,
  output logic [PSUM_W-1:0]        acc
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = PSUM_W - PROD_W;

  logic signed [PROD_W-1:0] prod;
  logic                     prod_vld;
  logic [PSUM_W-1:0]        prod_ext;
  logic [PSUM_W-1:0]        acc_next;

  // Product pipeline stage: prod_vld marks that prod holds a fresh tap
  // which must be folded into the accumulator on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else if (clear) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= mul_en;
      if (mul_en) begin
        prod <= w * x;
      end
    end
  end

  assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};

`ifdef PE_PSUM_SAT_EN
  localparam logic [PSUM_W-1:0] SAT_MAX = {1'b0, {(PSUM_W-1){1'b1}}};
  localparam logic [PSUM_W-1:0] SAT_MIN = {1'b1, {(PSUM_W-1){1'b0}}};

  logic [PSUM_W:0] sum_wide;

  // One guard bit catches signed overflow: if the top two bits disagree the
  // true sum left the PSUM_W range, and the guard bit tells which way.
  always_comb begin
    sum_wide = {acc[PSUM_W-1], acc} + {prod_ext[PSUM_W-1], prod_ext};
    if (sum_wide[PSUM_W] != sum_wide[PSUM_W-1]) begin
      acc_next = sum_wide[PSUM_W] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_next = sum_wide[PSUM_W-1:0];
    end
  end
`else
  // Plain two's complement add; overflow wraps modulo 2^PSUM_W.
  always_comb begin
    acc_next = acc + prod_ext;
  end
`endif

  // Accumulator: a load from the upstream psum always wins over an
  // accumulate; the controller never asks for both in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_data;
    end else if (prod_vld) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pe_mac_ctrl.sv
// pe_mac_ctrl
//   Sequences a stride-1 1-D row convolution over the weight and ifmap
//   scratchpads: for each output o, psum = psum_in + sum_k w[k]*x[o+k].
//   Partial sums arrive from the upstream PE and leave downstream over
//   valid/ready handshakes.
//   Build option: PE_PSUM_SAT_EN (saturating accumulate, see pe_mac_unit).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start                    : one-cycle pulse, accepted only in IDLE
//   cfg_filt_len             : taps L (1..63), latched on start
//   cfg_num_out              : outputs N (1..63), latched on start
//   busy                     : run in progress
//   done                     : one-cycle pulse after the last output is taken
//   w_r_en/w_r_addr/w_r_data : weight scratchpad read (combinational data)
//   x_r_en/x_r_addr/x_r_data : ifmap scratchpad read (combinational data)
//   psum_in_*                : upstream partial sum, ready only in LOAD
//   psum_out_*               : accumulated result, valid only in OUT
module pe_mac_ctrl #(
  parameter int DATA_W = pe_pkg::DATA_W,
  parameter int ADDR_W = pe_pkg::ADDR_W,
  parameter int PSUM_W = pe_pkg::PSUM_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        cfg_filt_len,
  input  logic [ADDR_W-1:0]        cfg_num_out,
  output logic                     busy,
  output logic                     done,
  output logic                     w_r_en,
  output logic [ADDR_W-1:0]        w_r_addr,
  input  logic signed [DATA_W-1:0] w_r_data,
  output logic                     x_r_en,
  output logic [ADDR_W-1:0]        x_r_addr,
  input  logic signed [DATA_W-1:0] x_r_data,
  input  logic                     psum_in_valid,
  output logic                     psum_in_ready,
  input  logic [PSUM_W-1:0]        psum_in_data,
  output logic                     psum_out_valid,
  input  logic                     psum_out_ready,
  output logic [PSUM_W-1:0]        psum_out_data
);

  import pe_pkg::*;

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0] filt_len;
  logic [ADDR_W-1:0] num_out;
  logic [ADDR_W-1:0] o_cnt;
  logic [ADDR_W-1:0] k_cnt;
  logic              done_r;
  logic [PSUM_W-1:0] acc;

  logic start_ok;
  logic in_fire;
  logic out_fire;
  logic last_tap;
  logic last_out;
  logic in_mac;

  assign start_ok = (state == IDLE) && start && (cfg_filt_len != '0) && (cfg_num_out != '0);
  assign in_fire  = (state == LOAD) && psum_in_valid;
  assign out_fire = (state == OUT) && psum_out_ready;
  assign last_tap = (k_cnt == filt_len - 1'b1);
  assign last_out = (o_cnt == num_out - 1'b1);
  assign in_mac   = (state == MAC);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Each output walks LOAD -> MAC (L cycles) -> DRAIN ->
  // OUT; DRAIN exists only to let the last registered product land in acc.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = LOAD;
      LOAD:    if (psum_in_valid) state_next = MAC;
      MAC:     if (last_tap) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     if (psum_out_ready) state_next = last_out ? IDLE : LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Configuration and loop counters. cfg is captured only on an accepted
  // start, so a start pulse during a run cannot disturb the latched values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_len <= '0;
      num_out  <= '0;
      o_cnt    <= '0;
      k_cnt    <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= out_fire && last_out;
      if (start_ok) begin
        filt_len <= cfg_filt_len;
        num_out  <= cfg_num_out;
        o_cnt    <= '0;
      end
      if (in_fire) begin
        k_cnt <= '0;
      end else if (in_mac) begin
        k_cnt <= k_cnt + 1'b1;
      end
      if (out_fire && !last_out) begin
        o_cnt <= o_cnt + 1'b1;
      end
    end
  end

  // Scratchpad reads happen only while stepping taps; the ifmap address
  // wraps naturally in ADDR_W bits.
  always_comb begin
    w_r_en   = in_mac;
    x_r_en   = in_mac;
    w_r_addr = in_mac ? k_cnt : '0;
    x_r_addr = in_mac ? (o_cnt + k_cnt) : '0;
  end

  // Handshake and status outputs are decoded straight from state so they
  // all read 0 the instant reset is applied.
  always_comb begin
    busy           = (state != IDLE);
    done           = done_r;
    psum_in_ready  = (state == LOAD);
    psum_out_valid = (state == OUT);
    psum_out_data  = (state == OUT) ? acc : '0;
  end

  pe_mac_unit #(
    .DATA_W (DATA_W),
    .PSUM_W (PSUM_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .load      (in_fire),
    .load_data (psum_in_data),
    .mul_en    (in_mac),
    .w         (w_r_data),
    .x         (x_r_data),
    .acc       (acc)
  );

endmodule

// File: tb/tb_pe_mac_ctrl.sv
// tb_pe_mac_ctrl
//   Self-checking bench for pe_mac_ctrl. Scratchpads are modelled as
//   combinational arrays; expected psums are computed from the convolution
//   definition, queued at stimulus time and popped when the DUT hands a
//   result downstream. Honours PE_PSUM_SAT_EN in its reference model.
module tb_pe_mac_ctrl;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int PW = 20;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_filt_len;
  logic [AW-1:0] cfg_num_out;
  logic          busy;
  logic          done;
  logic          w_r_en;
  logic [AW-1:0] w_r_addr;
  logic signed [DW-1:0] w_r_data;
  logic          x_r_en;
  logic [AW-1:0] x_r_addr;
  logic signed [DW-1:0] x_r_data;
  logic          psum_in_valid;
  logic          psum_in_ready;
  logic [PW-1:0] psum_in_data;
  logic          psum_out_valid;
  logic          psum_out_ready;
  logic [PW-1:0] psum_out_data;

  logic signed [DW-1:0] w_mem [64];
  logic signed [DW-1:0] x_mem [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_acc_cyc = -1;
  int exp_q [$];
  logic          hold_active = 1'b0;
  logic [PW-1:0] hold_data = '0;

  pe_mac_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_filt_len   (cfg_filt_len),
    .cfg_num_out    (cfg_num_out),
    .busy           (busy),
    .done           (done),
    .w_r_en         (w_r_en),
    .w_r_addr       (w_r_addr),
    .w_r_data       (w_r_data),
    .x_r_en         (x_r_en),
    .x_r_addr       (x_r_addr),
    .x_r_data       (x_r_data),
    .psum_in_valid  (psum_in_valid),
    .psum_in_ready  (psum_in_ready),
    .psum_in_data   (psum_in_data),
    .psum_out_valid (psum_out_valid),
    .psum_out_ready (psum_out_ready),
    .psum_out_data  (psum_out_data)
  );

  assign w_r_data = w_r_en ? w_mem[w_r_addr] : '0;
  assign x_r_data = x_r_en ? x_mem[x_r_addr] : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int wrapPsum(input int v);
    int r;
    r = v & ((1 << PW) - 1);
    if (r >= (1 << (PW - 1))) r = r - (1 << PW);
    return r;
  endfunction

  // Reference: psum_in + sum_k w[k]*x[o+k], accumulated one tap at a time.
  function automatic int model(input int l, input int o, input int pin);
    int acc;
    int p;
    acc = pin;
    for (int k = 0; k < l; k++) begin
      p = int'(w_mem[k]) * int'(x_mem[(o + k) % 64]);
      acc = acc + p;
`ifdef PE_PSUM_SAT_EN
      if (acc > (1 << (PW - 1)) - 1) acc = (1 << (PW - 1)) - 1;
      else if (acc < -(1 << (PW - 1))) acc = -(1 << (PW - 1));
`else
      acc = wrapPsum(acc);
`endif
    end
    return acc;
  endfunction

  // Output monitor: pops the scoreboard on every downstream transfer,
  // checks stability under backpressure and that no scratchpad is read
  // while the DUT is stalled on either handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_active = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (psum_out_valid) begin
          checkOutput("rd_in_out", {30'd0, w_r_en, x_r_en}, 0);
          if (hold_active) checkOutput("hold_data", $signed(psum_out_data), $signed(hold_data));
          if (psum_out_ready) begin
            if (exp_q.size() == 0) checkOutput("sb_underflow", exp_q.size(), 1);
            else checkOutput("psum_out", $signed(psum_out_data), exp_q.pop_front());
            last_acc_cyc = cyc;
            hold_active = 1'b0;
          end else begin
            hold_active = 1'b1;
            hold_data = psum_out_data;
          end
        end else begin
          hold_active = 1'b0;
        end
        if (psum_in_ready && !psum_in_valid) begin
          checkOutput("rd_in_load", {30'd0, w_r_en, x_r_en}, 0);
        end
      end
    end
  end

  task automatic checkIdle(input string pfx);
    checkOutput({pfx, "_busy"}, busy, 0);
    checkOutput({pfx, "_done"}, done, 0);
    checkOutput({pfx, "_wen"}, w_r_en, 0);
    checkOutput({pfx, "_waddr"}, w_r_addr, 0);
    checkOutput({pfx, "_xen"}, x_r_en, 0);
    checkOutput({pfx, "_xaddr"}, x_r_addr, 0);
    checkOutput({pfx, "_inrdy"}, psum_in_ready, 0);
    checkOutput({pfx, "_outvld"}, psum_out_valid, 0);
    checkOutput({pfx, "_outdata"}, psum_out_data, 0);
  endtask

  task automatic pulseStart(input int l, input int n);
    cfg_filt_len = AW'(l);
    cfg_num_out  = AW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs one complete job. in_stall/out_stall hold psum_in_valid or
  // psum_out_ready low for that many cycles; poke pulses a bogus start
  // while the first output is being computed.
  task automatic applyStimulus(input int l, input int n, input int pin_q[$],
                               input int in_stall, input int out_stall, input bit poke);
    int base_done;
    int cnt;
    bit ok;
    base_done = done_cnt;
    for (int o = 0; o < n; o++) exp_q.push_back(model(l, o, pin_q[o]));
    psum_out_ready = (out_stall == 0);
    @(posedge clk); #1;
    pulseStart(l, n);
    checkOutput("busy_start", busy, 1);
    for (int o = 0; o < n; o++) begin
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        if (psum_in_ready) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      checkOutput("load_seen", ok, 1);
      repeat (in_stall) begin
        @(posedge clk); #1;
      end
      psum_in_valid = 1'b1;
      psum_in_data  = PW'(pin_q[o]);
      @(posedge clk); #1;
      psum_in_valid = 1'b0;
      cnt = 0;
      if (poke && o == 0) begin
        pulseStart(7, 5);
        cnt = 1;
      end
      while (!psum_out_valid && cnt < 300) begin
        @(posedge clk); #1;
        cnt++;
      end
      checkOutput("out_seen", psum_out_valid, 1);
      checkOutput("mac_latency", cnt, l + 1);
      if (out_stall > 0) begin
        repeat (out_stall) begin
          @(posedge clk); #1;
        end
        checkOutput("out_held", psum_out_valid, 1);
        psum_out_ready = 1'b1;
        @(posedge clk); #1;
        psum_out_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("done_count", done_cnt - base_done, 1);
    checkOutput("done_timing", done_cyc, last_acc_cyc + 1);
    checkOutput("busy_end", busy, 0);
    checkOutput("sb_drained", exp_q.size(), 0);
  endtask

  task automatic loadBasic();
    for (int i = 0; i < 64; i++) begin
      w_mem[i] = '0;
      x_mem[i] = DW'(i + 1);
    end
    w_mem[0] = 8'sd1;
    w_mem[1] = 8'sd2;
    w_mem[2] = 8'sd3;
  endtask

  initial begin
    int pin_q [$];
    int base_done;
    bit ok;
    rst = 1'b1;
    start = 1'b0;
    cfg_filt_len = '0;
    cfg_num_out = '0;
    psum_in_valid = 1'b0;
    psum_in_data = '0;
    psum_out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w_mem[i] = '0;
      x_mem[i] = '0;
    end
    #1;
    checkIdle("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] basic");
    loadBasic();
    checkOutput("model_basic0", model(3, 0, 0), 14);
    checkOutput("model_basic1", model(3, 1, 10), 30);
    pin_q = '{0, 10};
    applyStimulus(3, 2, pin_q, 0, 0, 1'b0);

    $display("[TB] signed");
    w_mem[0] = -8'sd128; w_mem[1] = 8'sd127;
    x_mem[0] = -8'sd128; x_mem[1] = -8'sd1;
    checkOutput("model_signed", model(2, 0, -5), 16252);
    pin_q = '{-5};
    applyStimulus(2, 1, pin_q, 0, 0, 1'b0);

    $display("[TB] backpressure");
    loadBasic();
    pin_q = '{0, 10};
    applyStimulus(3, 2, pin_q, 4, 5, 1'b0);

    $display("[TB] start during run");
    pin_q = '{0, 10};
    applyStimulus(3, 2, pin_q, 0, 0, 1'b1);

    $display("[TB] random");
    for (int i = 0; i < 64; i++) begin
      w_mem[i] = DW'($urandom_range(0, 255));
      x_mem[i] = DW'($urandom_range(0, 255));
    end
    pin_q = {};
    for (int o = 0; o < 6; o++) pin_q.push_back(int'($urandom_range(0, 200000)) - 100000);
    applyStimulus(5, 6, pin_q, 1, 2, 1'b0);

    $display("[TB] overflow");
    for (int i = 0; i < 64; i++) begin
      w_mem[i] = -8'sd128;
      x_mem[i] = -8'sd128;
    end
`ifdef PE_PSUM_SAT_EN
    checkOutput("model_ovf", model(32, 0, 0), 524287);
`else
    checkOutput("model_ovf", model(32, 0, 0), -524288);
`endif
    pin_q = '{0};
    applyStimulus(32, 1, pin_q, 0, 0, 1'b0);

    $display("[TB] start guards");
    @(posedge clk); #1;
    pulseStart(0, 2);
    checkOutput("guard_l0_busy", busy, 0);
    checkOutput("guard_l0_rdy", psum_in_ready, 0);
    pulseStart(3, 0);
    checkOutput("guard_n0_busy", busy, 0);
    checkOutput("guard_n0_rdy", psum_in_ready, 0);

    $display("[TB] reset mid-run");
    loadBasic();
    base_done = done_cnt;
    pulseStart(5, 1);
    psum_in_valid = 1'b1;
    psum_in_data = PW'(7);
    @(posedge clk); #1;
    psum_in_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (w_r_en && w_r_addr == AW'(2)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput("reach_k2", ok, 1);
    rst = 1'b1;
    #1;
    checkIdle("midrst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("midrst_no_done", done_cnt - base_done, 0);
    checkOutput("midrst_busy", busy, 0);

    $display("[TB] basic after reset");
    loadBasic();
    pin_q = '{0, 10};
    applyStimulus(3, 2, pin_q, 0, 0, 1'b0);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
